// File: rtl/board_input_ctrl_pkg.sv
// Register map and button bit positions shared by the input block and the
// CPU-side address decode.
package board_io_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ADDR_SW  = 2'd0,
    ADDR_BTN = 2'd1,
    ADDR_EVT = 2'd2,
    ADDR_IEN = 2'd3
  } reg_addr_e;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

endpackage

// File: rtl/board_input_ctrl_if.sv
// Memory-mapped register port between the CPU (master) and the board input
// block (slave).
interface board_input_ctrl_if;
  import board_io_pkg::*;

  logic [1:0]        addr;
  logic              rd_en;
  logic              wr_en;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              irq;

  modport master (output addr, rd_en, wr_en, wdata, input rdata, irq);
  modport slave  (input addr, rd_en, wr_en, wdata, output rdata, irq);

endinterface

// File: rtl/board_input_ctrl_debounce_cell.sv
// One input bit: 2-flop synchronizer, tick-sampled stability counter and the
// accepted (stable) level.
module debounce_cell #(
  parameter int DB_TICKS = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DB_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      stable  <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // Only tick samples count; any disagreeing-free tick restarts the run.
      if (tick) begin
        if (sync_p1 == stable) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          stable <= sync_p1;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/board_input_ctrl.sv
// Board switch/button conditioning with a 4-word register port.
// Optional IEN register and irq output enabled by defining INPUT_IRQ_EN.
module board_input_ctrl
  import board_io_pkg::*;
#(
  parameter int N_SW     = 16,
  parameter int N_BTN    = 5,
  parameter int TICK_DIV = 100000,
  parameter int DB_TICKS = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_BTN-1:0] btn_raw,
  board_input_ctrl_if.slave bus
);

  localparam int NB = N_SW + N_BTN;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic [NB-1:0]     raw_all;
  logic [NB-1:0]     stb_all;
  logic [N_SW-1:0]   sw_stb;
  logic [N_BTN-1:0]  btn_stb;
  logic [N_BTN-1:0]  btn_prev;
  logic [N_BTN-1:0]  evt;
  logic [N_BTN-1:0]  evt_nxt;
  logic [N_BTN-1:0]  w1c;
  logic [N_BTN-1:0]  ien;
  logic [DATA_W-1:0] rd_mux;
  logic              unused_wdata;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  assign raw_all = {btn_raw, sw_raw};

  for (genvar i = 0; i < NB; i++) begin : g_db
    debounce_cell #(.DB_TICKS(DB_TICKS)) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .tick   (tick),
      .raw    (raw_all[i]),
      .stable (stb_all[i])
    );
  end

  assign sw_stb  = stb_all[N_SW-1:0];
  assign btn_stb = stb_all[NB-1:N_SW];

  // Press set is OR-ed in after the clear so a same-cycle press survives W1C.
  always_comb begin
    w1c     = '0;
    if (bus.wr_en && bus.addr == ADDR_EVT) w1c = bus.wdata[N_BTN-1:0];
    evt_nxt = (evt & ~w1c) | (btn_stb & ~btn_prev);
  end

  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      ADDR_SW:  rd_mux[N_SW-1:0]  = sw_stb;
      ADDR_BTN: rd_mux[N_BTN-1:0] = btn_stb;
      ADDR_EVT: rd_mux[N_BTN-1:0] = evt;
      ADDR_IEN: rd_mux[N_BTN-1:0] = ien;
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_prev  <= '0;
      evt       <= '0;
      bus.rdata <= '0;
    end else begin
      btn_prev <= btn_stb;
      evt      <= evt_nxt;
      if (bus.rd_en) bus.rdata <= rd_mux;
    end
  end

`ifdef INPUT_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ien   <= '0;
      irq_q <= 1'b0;
    end else begin
      if (bus.wr_en && bus.addr == ADDR_IEN) ien <= bus.wdata[N_BTN-1:0];
      irq_q <= |(evt & ien);
    end
  end

  assign bus.irq = irq_q;
`else
  assign ien     = '0;
  assign bus.irq = 1'b0;
`endif

  assign unused_wdata = ^bus.wdata[DATA_W-1:N_BTN];

endmodule
